// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and the divide-by-zero LO value.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_e;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide datapath.
// Ports:
//   is_div          - 1: restoring shift-subtract step, 0: shift-add step
//   acc_hi, acc_lo  - current 2*XLEN accumulator
//   operand         - multiplicand (mul) or divisor (div), magnitude form
//   nxt_hi, nxt_lo  - accumulator after this step
// Mul: acc_lo holds the remaining multiplier bits, the product grows into acc_hi
//      and shifts down into acc_lo.
// Div: acc_lo holds the dividend, shifted out into the partial remainder in
//      acc_hi; quotient bits shift in at the bottom of acc_lo.
module muldiv_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] acc_hi,
    input  logic [XLEN-1:0] acc_lo,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] nxt_hi,
    output logic [XLEN-1:0] nxt_lo
);

    logic [XLEN:0] sum;
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;
    logic          fits;

    always_comb begin
        sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        // Partial remainder can reach XLEN+1 bits, so compare at full width.
        rem_sh = {acc_hi, acc_lo[XLEN-1]};
        diff   = rem_sh - {1'b0, operand};
        fits   = (rem_sh >= {1'b0, operand});
        nxt_hi = sum[XLEN:1];
        nxt_lo = {sum[0], acc_lo[XLEN-1:1]};
        if (is_div) begin
            nxt_hi = fits ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
            nxt_lo = {acc_lo[XLEN-2:0], fits};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit owning the architectural HI/LO pair.
// Ports:
//   clk, reset       - clock (rising edge), asynchronous active-high reset
//   start, op        - launch mult/multu/div/divu; sampled only when idle
//   srca, srcb       - rs/rt operands
//   hi_we, lo_we     - mthi/mtlo write enables, wdata is the write value
//   busy             - operation in progress (combinational from state)
//   done             - one-cycle pulse when an operation has written HI/LO
//   hi, lo           - HI/LO registers
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ITER = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(ITER);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   acc_hi_q, acc_hi_d;
    logic [XLEN-1:0]   acc_lo_q, acc_lo_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              done_q, done_d;

    logic              in_signed, in_div, in_sa, in_sb;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN-1:0]   step_hi, step_lo;
    logic              neg;
    logic [2*XLEN-1:0] prod, mul_res;
    logic [XLEN-1:0]   quo, rem, fix_hi, fix_lo;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div  (op_q[1]),
        .acc_hi  (acc_hi_q),
        .acc_lo  (acc_lo_q),
        .operand (opb_q),
        .nxt_hi  (step_hi),
        .nxt_lo  (step_lo)
    );

    // Operand conditioning at launch and sign correction of the finished accumulator.
    always_comb begin
        in_signed = (op == OP_MULT) || (op == OP_DIV);
        in_div    = (op == OP_DIV) || (op == OP_DIVU);
        in_sa     = in_signed & srca[XLEN-1];
        in_sb     = in_signed & srcb[XLEN-1];
        mag_a     = in_sa ? -srca : srca;
        mag_b     = in_sb ? -srcb : srcb;

        neg       = sign_a_q ^ sign_b_q;
        prod      = {acc_hi_q, acc_lo_q};
        mul_res   = neg ? -prod : prod;
        quo       = neg ? -acc_lo_q : acc_lo_q;
        // Remainder follows the dividend; on divide-by-zero it equals |srca|, so this restores srca.
        rem       = sign_a_q ? -acc_hi_q : acc_hi_q;
        fix_hi    = op_q[1] ? rem : mul_res[2*XLEN-1:XLEN];
        fix_lo    = op_q[1] ? quo : mul_res[XLEN-1:0];
        if (op_q[1] && (opb_q == '0)) begin
            fix_lo = XLEN'(DIV0_LO);
        end
    end

    // Next-state and register update logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        opb_d    = opb_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d     = op;
                    sign_a_d = in_sa;
                    sign_b_d = in_sb;
                    acc_hi_d = '0;
                    acc_lo_d = in_div ? mag_a : mag_b;
                    opb_d    = in_div ? mag_b : mag_a;
                    cnt_d    = CNT_W'(ITER - 1);
                    state_d  = RUN;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            RUN: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FIX: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            opb_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            opb_q    <= opb_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random
// operations against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srca, srcb;
    logic        hi_we, lo_we;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .srca  (srca),
        .srcb  (srcb),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Returns {hi, lo} computed with plain 64-bit arithmetic.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] q, r;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            2'b00: ref_model = 64'(sa * sb);
            2'b01: ref_model = {32'd0, a} * {32'd0, b};
            default: begin
                if (b == 32'd0) begin
                    ref_model = {a, 32'hFFFF_FFFF};
                end else begin
                    if (o == 2'b10) begin
                        q = 64'(sa / sb);
                        r = 64'(sa % sb);
                    end else begin
                        q = {32'd0, a / b};
                        r = {32'd0, a % b};
                    end
                    ref_model = {r[31:0], q[31:0]};
                end
            end
        endcase
    endfunction

    // Launch one op and check latency, busy, HI/LO hold during the run, result and done width.
    // disturb: fire a second start plus mthi/mtlo mid-run; we_at_start: assert writes with start.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit disturb, input bit we_at_start,
                         input string tag);
        int          lat;
        bit          early, moved;
        logic [63:0] prev;
        @(negedge clk);
        prev  = {hi, lo};
        start = 1'b1;
        op    = o;
        srca  = a;
        srcb  = b;
        hi_we = we_at_start;
        lo_we = we_at_start;
        wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        op    = 2'($urandom);
        srca  = $urandom;
        srcb  = $urandom;
        lat   = 0;
        early = 1'b0;
        moved = 1'b0;
        while (!done && lat < 100) begin
            if (!busy) early = 1'b1;
            if ({hi, lo} !== prev) moved = 1'b1;
            if (disturb && lat == 5) begin
                start = 1'b1;
                op    = ~o;
                srca  = 32'd5;
                srcb  = 32'd3;
                hi_we = 1'b1;
                lo_we = 1'b1;
                wdata = 32'h1234_5678;
            end else begin
                start = 1'b0;
                hi_we = 1'b0;
                lo_we = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        chk({tag, "_latency"}, 64'(lat), 64'd33);
        chk({tag, "_busy_early_drop"}, {63'd0, early}, 64'd0);
        chk({tag, "_hilo_held"}, {63'd0, moved}, 64'd0);
        chk({tag, "_result"}, {hi, lo}, exp);
        chk({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        srca  = '0;
        srcb  = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        repeat (2) @(negedge clk);
        chk("reset_state", {hi, lo, 28'd0, 2'b00, busy, done}, 64'd0);
        reset = 1'b0;

        // mthi / mtlo in idle
        @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi", {hi, lo}, {32'hA5A5_A5A5, 32'd0});
        lo_we = 1'b1;
        wdata = 32'h5A5A_0001;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo", {hi, lo}, {32'hA5A5_A5A5, 32'h5A5A_0001});
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h0F0F_0F0F;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        chk("mthi_mtlo_both", {hi, lo}, {32'h0F0F_0F0F, 32'h0F0F_0F0F});

        // Reset in the middle of a multu aborts without touching HI/LO beyond clearing them
        start = 1'b1;
        op    = 2'b01;
        srca  = 32'd7;
        srcb  = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("reset_midop", {hi, lo, 30'd0, busy, done}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        do_op(2'b01, 32'd7, 32'd6, {32'd0, 32'd42}, 1'b0, 1'b0, "multu_7x6");
        do_op(2'b00, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA}, 1'b0, 1'b0, "mult_neg");
        do_op(2'b01, 32'hFFFF_FFFE, 32'd3, {32'h0000_0002, 32'hFFFF_FFFA}, 1'b0, 1'b0, "multu_big");
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, 1'b0, "div_neg7_2");
        do_op(2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 1'b0, "divu_100_7");
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0, 1'b0, "div_ovf");
        do_op(2'b11, 32'd1234, 32'd0, {32'd1234, 32'hFFFF_FFFF}, 1'b0, 1'b0, "divu_by0");
        do_op(2'b10, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1'b0, 1'b0, "div_neg_by0");
        do_op(2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b1, 1'b0, "busy_ignores");
        do_op(2'b01, 32'd9, 32'd9, {32'd0, 32'd81}, 1'b0, 1'b1, "start_drops_we");

        for (int i = 0; i < 1000; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 7) == 0) rb = 32'($urandom_range(0, 15));
            do_op(ro, ra, rb, ref_model(ro, ra, rb), 1'b0, 1'b0, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit feeding the HI/LO registers that mfhi/mflo read in the MIPS core datapath.
- Accepts one operation at a time from the decoder/datapath (mult, multu, div, divu), computes over 32 iterations and holds the results in architectural HI/LO.
- Asserts busy while working so the core stalls any following mfhi/mflo/mthi/mtlo or muldiv op.
- Also services mthi/mtlo writes.

Parameters:
- XLEN, 32, operand and HI/LO width; only 32 is supported.
- ITER, 32, iteration count of the RUN state; must equal XLEN.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  launch operation; sampled only in IDLE
- op  in  2  00 mult, 01 multu, 10 div, 11 divu
- srca  in  32  rs operand (multiplicand / dividend)
- srcb  in  32  rt operand (multiplier / divisor)
- hi_we  in  1  mthi write enable
- lo_we  in  1  mtlo write enable
- wdata  in  32  mthi/mtlo data
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: HI/LO just updated by an operation
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (async): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal operand regs=0. Reset mid-operation aborts; no partial HI/LO update.
- busy = (state != IDLE), combinational from the state register. done, hi and lo are registered.
- States:
  - IDLE: if start=1 at edge E0, latch op, sign flags (signed ops only) and magnitudes |srca|, |srcb| (unsigned ops: raw values); counter=ITER-1; go to RUN.
  - RUN: one shift-add (mul) or restoring shift-subtract (div) step per edge, 64-bit accumulator {hi_acc, lo_acc}. Counter decrements; at counter=0 go to FIX.
  - FIX: apply sign correction, write hi/lo, set done=1, go to IDLE.
- Timing: start sampled at E0; RUN spans E1..E32; FIX at E33. busy=1 for 33 cycles (after E0 until E33). done=1 and new hi/lo visible in the cycle after E33; done drops at E34.
- Arithmetic:
  - mult/multu: {hi,lo} = full 64-bit product.
  - Signed mult: negate the 64-bit magnitude product when sign(a)^sign(b).
  - div/divu: lo = quotient, hi = remainder, truncating toward zero.
  - Signed div: quotient negated if sign(a)^sign(b); remainder takes the sign of the dividend.
- Boundary conditions:
  - Divide by zero (srcb=0, any div op): full latency, then hi=srca (original value), lo=32'hFFFF_FFFF.
  - Signed overflow 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0.
  - start while busy: ignored; no queuing.
  - start and hi_we/lo_we together in IDLE: start is accepted; the writes are dropped.
  - hi_we/lo_we in IDLE without start: next edge writes wdata into hi and/or lo; both may assert together.
  - hi_we/lo_we while busy: ignored. The core must stall on busy.
  - hi/lo hold their old values throughout RUN; only FIX or mthi/mtlo change them.
- No X propagation: op/srca/srcb are don't-care when start=0.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  - state enum IDLE, RUN, FIX
  - constant DIV0_LO = 32'hFFFF_FFFF
- Natural sub-module: muldiv_step. Purely combinational single iteration: takes {acc_hi, acc_lo}, divisor/multiplicand and mode; returns the next accumulator. The top block holds the FSM, counter, sign fix and HI/LO registers.

Test Plan:
- Reset mid-op:
  - Stimulus: reset high, then start op=01 with srca=7, srcb=6; assert reset at E10.
  - Response: hi=lo=0, busy=0 immediately. After a fresh multu 7*6: done pulse after E33, hi=0, lo=42, busy=1 for exactly 33 cycles.
- mult with a negative operand:
  - Stimulus: op=00, srca=0xFFFF_FFFE (-2), srcb=3.
  - Response: hi=0xFFFF_FFFF, lo=0xFFFF_FFFA. Same operands with multu: hi=0x0000_0002, lo=0xFFFF_FFFA.
- Signed and unsigned divide:
  - div: srca=-7, srcb=2 gives lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1).
  - divu: srca=100, srcb=7 gives lo=14, hi=2.
- Division corner cases:
  - div 0x8000_0000 / 0xFFFF_FFFF gives lo=0x8000_0000, hi=0.
  - divu 1234 / 0 gives hi=1234, lo=0xFFFF_FFFF after full latency.
- Register writes versus busy:
  - In IDLE, hi_we=1 with wdata=0xA5A5_A5A5: hi updates next cycle, lo unchanged.
  - During busy, lo_we=1 and a second start: both ignored; the final result equals the first op's result.
- Random regression:
  - 1000 random op/srca/srcb triples checked against a 64-bit reference model.
  - Assert done is exactly one cycle, 33 edges after start, and busy never drops early.
